// File: rtl/compare_stats_4bits.sv
// compare_stats_4bits: windowed gt/eq/lt/err statistics of comparator codes with an eq-run flag
module compare_stats_4bits #(
  parameter int WINDOW = 16,
  parameter int RUN_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       y_valid,
  output logic       y_ready,
  input  logic [2:0] y,
  input  logic       clr,
  output logic       rpt_valid,
  input  logic       rpt_ready,
  output logic [7:0] rpt_gt,
  output logic [7:0] rpt_eq,
  output logic [7:0] rpt_lt,
  output logic [7:0] rpt_err,
  output logic       eq_run
);
  typedef enum logic {COLLECT, REPORT} state_t;
  localparam logic [7:0] LAST = 8'(WINDOW - 1);
  localparam logic [7:0] RUN_MAX = 8'(RUN_LEN);
  state_t state_q, state_d;
  logic [7:0] gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, err_q, err_d;
  logic [7:0] cnt_q, cnt_d, run_q, run_d;
  logic [7:0] rgt_q, rgt_d, req_q, req_d, rlt_q, rlt_d, rerr_q, rerr_d;
  logic       eq_run_q, eq_run_d;
  logic       is_gt, is_eq, is_lt, is_err;
  logic [7:0] gt_n, eq_n, lt_n, err_n;
  assign is_gt  = y == 3'b100;
  assign is_eq  = y == 3'b010;
  assign is_lt  = y == 3'b001;
  assign is_err = !(is_gt || is_eq || is_lt);
  assign gt_n  = gt_q + 8'(is_gt && gt_q != 8'hff);
  assign eq_n  = eq_q + 8'(is_eq && eq_q != 8'hff);
  assign lt_n  = lt_q + 8'(is_lt && lt_q != 8'hff);
  assign err_n = err_q + 8'(is_err && err_q != 8'hff);
  always_comb begin
    state_d = state_q;
    gt_d = gt_q;
    eq_d = eq_q;
    lt_d = lt_q;
    err_d = err_q;
    cnt_d = cnt_q;
    run_d = run_q;
    rgt_d = rgt_q;
    req_d = req_q;
    rlt_d = rlt_q;
    rerr_d = rerr_q;
    if (state_q == COLLECT) begin
      if (clr) begin
        {gt_d, eq_d, lt_d, err_d, cnt_d, run_d} = '0;
      end else if (y_valid) begin
        run_d = is_eq ? (run_q == RUN_MAX ? run_q : run_q + 8'd1) : 8'd0;
        // Final sample of the window goes straight into the report registers
        if (cnt_q == LAST) begin
          state_d = REPORT;
          {rgt_d, req_d, rlt_d, rerr_d} = {gt_n, eq_n, lt_n, err_n};
          {gt_d, eq_d, lt_d, err_d, cnt_d} = '0;
        end else begin
          {gt_d, eq_d, lt_d, err_d} = {gt_n, eq_n, lt_n, err_n};
          cnt_d = cnt_q + 8'd1;
        end
      end
    end else if (rpt_ready) begin
      state_d = COLLECT;
    end
    eq_run_d = run_d == RUN_MAX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      {gt_q, eq_q, lt_q, err_q, cnt_q, run_q} <= '0;
      {rgt_q, req_q, rlt_q, rerr_q} <= '0;
      eq_run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      {gt_q, eq_q, lt_q, err_q, cnt_q, run_q} <= {gt_d, eq_d, lt_d, err_d, cnt_d, run_d};
      {rgt_q, req_q, rlt_q, rerr_q} <= {rgt_d, req_d, rlt_d, rerr_d};
      eq_run_q <= eq_run_d;
    end
  end
  assign y_ready   = state_q == COLLECT;
  assign rpt_valid = state_q == REPORT;
  assign rpt_gt    = rgt_q;
  assign rpt_eq    = req_q;
  assign rpt_lt    = rlt_q;
  assign rpt_err   = rerr_q;
  assign eq_run    = eq_run_q;
endmodule

// File: doc/compare_stats_4bits.md
COMPARE_STATS_4BITS -- requirements
Module: compare_stats_4bits

Interface
REQ-001 Parameter WINDOW, default 16: number of accepted comparison results per statistics window, legal range 2..255.
REQ-002 Parameter RUN_LEN, default 4: count of consecutive "equal" results that asserts eq_run, legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all logic rising-edge.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port y_valid, input, 1: y carries a comparator result this cycle.
REQ-006 Port y_ready, output, 1: block can accept a result this cycle.
REQ-007 Port y, input, 3: comparator code; y[2]=a>b, y[1]=a==b, y[0]=a<b.
REQ-008 Port clr, input, 1: synchronous abort of the current window.
REQ-009 Port rpt_valid, output, 1: report fields valid.
REQ-010 Port rpt_ready, input, 1: consumer accepts report.
REQ-011 Ports rpt_gt, rpt_eq, rpt_lt, rpt_err, output, 8 each: per-window counts of gt, eq, lt and malformed codes.
REQ-012 Port eq_run, output, 1: at least RUN_LEN consecutive accepted results were "equal".

Function
REQ-013 The block SHALL accept a result only when y_valid and y_ready are both high in the same cycle; this is an accept.
REQ-014 The FSM SHALL have the states COLLECT and REPORT; y_ready=1 only in COLLECT, rpt_valid=1 only in REPORT.
REQ-015 Each accept SHALL classify y as follows: 100 -> gt, 010 -> eq, 001 -> lt; any other code -> err.
REQ-016 Each accept SHALL increment exactly one working counter (gt, eq, lt or err) and the window sample counter.
REQ-017 The working counters SHALL saturate at 255; this occurs only if WINDOW exceeds 255, which is illegal, so saturation is a guard only.
REQ-018 The accept that brings the sample count to WINDOW SHALL be counted. On the next edge: state -> REPORT, working counts copied to the rpt_* registers, working counts and sample count zeroed.
REQ-019 In REPORT, rpt_* and rpt_valid SHALL hold stable until rpt_valid and rpt_ready are both high. State -> COLLECT on the following edge.
REQ-020 Report latency SHALL be 1 cycle: rpt_valid rises on the edge after the WINDOW-th accept.
REQ-021 While in REPORT, y_valid SHALL be ignored and no sample SHALL be lost: the upstream stalls because y_ready=0.
REQ-022 clr in COLLECT SHALL zero the working counts and sample count; the same-cycle accept SHALL be discarded; state is unchanged.
REQ-023 clr in REPORT SHALL have no effect on the pending report.
REQ-024 The run counter SHALL increment on an eq accept, saturating at RUN_LEN. Any non-eq accept, including err, SHALL zero it. Cycles without an accept SHALL leave it unchanged.
REQ-025 eq_run SHALL be a registered output, high when the run counter equals RUN_LEN. It rises on the edge of the RUN_LEN-th consecutive eq accept.
REQ-026 Window boundaries SHALL NOT reset the run counter; clr SHALL zero it.
REQ-027 rpt_* SHALL hold the last reported values while in COLLECT.

Reset
REQ-028 rst SHALL take priority over clr and all handshakes.
REQ-029 rst SHALL force state COLLECT, y_ready=1, rpt_valid=0, rpt_gt=rpt_eq=rpt_lt=rpt_err=0, eq_run=0, and zero all working, sample and run counters.
REQ-030 rst asserted mid-window or during REPORT SHALL discard the partial window and the pending report.

Verification (WINDOW=4, RUN_LEN=2 unless stated)
REQ-031 Accept y=010,100,001,010 with rpt_ready=1 -> rpt_valid is high for 1 cycle on the next edge with rpt_gt=1, rpt_eq=2, rpt_lt=1, rpt_err=0.
REQ-032 Accept y=000,111,110,100 -> report gives rpt_err=3, rpt_gt=1.
REQ-033 rpt_ready=0 for 5 cycles after the window with y_valid held high -> y_ready=0, rpt_* stable, and the first sample after release is counted in the next window.
REQ-034 Accept y=010,010,001 -> eq_run rises after the 2nd accept and falls after the 3rd. Accept y=010 across a window boundary -> the run continues.
REQ-035 Make 2 accepts, then clr with y_valid=1, then 4 accepts of 100 -> the single report gives rpt_gt=4; the clr-cycle sample is not counted.
REQ-036 Assert rst during REPORT -> next cycle rpt_valid=0, all rpt_*=0, y_ready=1, eq_run=0.
